// File: rtl/isramsd_req_encoder.sv
// ---------------------------------------------------------------------------
// isramsd_req_encoder
//
// Purpose: collects per-wordline request strobes into a pending register and
// hands them out one at a time as a registered 3-bit row address with a
// valid/ready handshake. There is one bubble cycle after each handshake.
//
// Ports:
//   clk      - single clock; all state updates on its rising edge
//   rst_n    - asynchronous active-low reset
//   enbl     - request-capture enable; when low, req is ignored
//   req[7:0] - request strobes; bit i requests row i
//   a[2:0]   - encoded row address (registered; holds its last value while idle)
//   a_valid  - a holds a valid encoded address
//   a_ready  - consumer accepts a on an edge where a_valid && a_ready
//   pend[7:0]- current pending-request register
//   ovf      - sticky flag: a request merged into an already-pending bit
//
// Handshake: once a_valid rises, a and a_valid stay stable until an edge on
// which a_ready is high; that edge completes the transfer and drops a_valid.
// a_ready while a_valid is low is ignored.
//
// Configuration: define ISRAMSD_RR_EN for round-robin selection (search starts
// one past the last granted index). Without it, the lowest-index pending bit
// wins and no pointer register exists.
// ---------------------------------------------------------------------------
module isramsd_req_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enbl,
  input  logic [7:0] req,
  output logic [2:0] a,
  output logic       a_valid,
  input  logic       a_ready,
  output logic [7:0] pend,
  output logic       ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic       a_valid_q, a_valid_d;
  logic [7:0] pend_q, pend_d;
  logic       ovf_q, ovf_d;

  logic [7:0] req_en;
  logic [7:0] clr;
  logic [2:0] grant_idx;

`ifdef ISRAMSD_RR_EN
  logic [2:0] ptr_q, ptr_d;

  // Search starts at ptr+1 and wraps through 3-bit arithmetic. Walking the
  // offsets downward lets the smallest offset overwrite the result last.
  always_comb begin
    logic [2:0] idx;
    grant_idx = 3'd0;
    idx       = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_q + 3'd1 + 3'(k);
      if (pend_q[idx]) grant_idx = idx;
    end
  end
`else
  // Fixed priority: the lowest set index is assigned last and so wins.
  always_comb begin
    grant_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) grant_idx = 3'(i);
    end
  end
`endif

  always_comb begin
    req_en    = req & {8{enbl}};
    state_d   = state_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;
    clr       = 8'h00;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          a_d       = grant_idx;
          a_valid_d = 1'b1;
          clr       = 8'h01 << grant_idx;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (a_ready) begin
          a_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        a_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // A new request on the bit being granted this edge survives the clear.
    pend_d = (pend_q & ~clr) | req_en;
    // Merging into a bit that is pending and not being granted loses a request.
    ovf_d  = ovf_q | (|(req_en & pend_q & ~clr));
  end

`ifdef ISRAMSD_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (clr != 8'h00) ptr_d = grant_idx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= 3'd0;
      a_valid_q <= 1'b0;
      pend_q    <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef ISRAMSD_RR_EN
  // Reset to 7 so the first search starts at index 0, matching fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 3'd7;
    else        ptr_q <= ptr_d;
  end
`endif

  assign a       = a_q;
  assign a_valid = a_valid_q;
  assign pend    = pend_q;
  assign ovf     = ovf_q;

endmodule
